// File: rtl/vertex_buffer_responder.sv
// Word-addressed memory slave with pipelined reads and an ordered response FIFO.
// Reads return READ_LATENCY cycles after acceptance unless resp_hold stalls issue.
module vertex_buffer_responder #(
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [25:0] slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [3:0]  slave_byteenable,
    input  logic [31:0] slave_writedata,
    output logic        slave_waitrequest,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid,
    input  logic        resp_hold,
    output logic [3:0]  pending_count,
    output logic        oob_error,
    output logic        protocol_error
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int FIFO_SLOTS = 1 << PW;
    localparam logic [3:0] MAX_P = 4'(MAX_PENDING);
    localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_PENDING - 1);

    logic [31:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   word_index;
    logic                    out_of_range;
    logic                    accept;
    logic                    read_accept;
    logic                    write_accept;
    logic                    unused_bits;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [31:0]             pipe_data [READ_LATENCY];
    logic                    pipe_out_valid;
    logic [31:0]             pipe_out_data;

    logic [31:0]             fifo_data [FIFO_SLOTS];
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;
    logic [3:0]              fifo_count;
    logic                    fifo_empty;
    logic                    issue;
    logic [31:0]             issue_data;
    logic                    push;
    logic                    pop;

    function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    assign word_index   = slave_address[DEPTH_LOG2+1:2];
    assign out_of_range = (slave_address >> (DEPTH_LOG2 + 2)) != '0;
    assign unused_bits  = ^slave_address[1:0];

    assign slave_waitrequest = (pending_count == MAX_P);
    assign accept       = reset && (slave_read || slave_write) && !slave_waitrequest;
    // A simultaneous read+write is serviced as a write only.
    assign read_accept  = accept && slave_read && !slave_write;
    assign write_accept = accept && slave_write;

    assign pipe_out_valid = pipe_valid[READ_LATENCY-1];
    assign pipe_out_data  = pipe_data[READ_LATENCY-1];
    assign fifo_empty     = (fifo_count == 4'd0);

    // Empty FIFO lets the pipeline output go straight to the response register.
    always_comb begin
        issue      = 1'b0;
        issue_data = pipe_out_data;
        push       = 1'b0;
        pop        = 1'b0;
        if (!resp_hold) begin
            issue = !fifo_empty || pipe_out_valid;
        end
        if (!fifo_empty) begin
            issue_data = fifo_data[rd_ptr];
        end
        pop  = issue && !fifo_empty;
        push = pipe_out_valid && !(issue && fifo_empty);
    end

    always_ff @(posedge clock) begin
        if (write_accept && !out_of_range) begin
            for (int b = 0; b < 4; b++) begin
                if (slave_byteenable[b]) begin
                    mem[word_index][8*b +: 8] <= slave_writedata[8*b +: 8];
                end
            end
        end
        pipe_data[0] <= out_of_range ? 32'h0 : mem[word_index];
        for (int s = 1; s < READ_LATENCY; s++) begin
            pipe_data[s] <= pipe_data[s-1];
        end
        if (push) begin
            fifo_data[wr_ptr] <= pipe_out_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipe_valid          <= '0;
            rd_ptr              <= '0;
            wr_ptr              <= '0;
            fifo_count          <= 4'd0;
            slave_readdatavalid <= 1'b0;
            slave_readdata      <= 32'h0;
            pending_count       <= 4'd0;
            oob_error           <= 1'b0;
            protocol_error      <= 1'b0;
        end else begin
            pipe_valid[0] <= read_accept;
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
            end

            if (push) wr_ptr <= next_slot(wr_ptr);
            if (pop)  rd_ptr <= next_slot(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 4'd1;
                2'b01:   fifo_count <= fifo_count - 4'd1;
                default: fifo_count <= fifo_count;
            endcase

            slave_readdatavalid <= issue;
            if (issue) slave_readdata <= issue_data;

            // A response leaves the count on the edge that ends its valid cycle.
            case ({read_accept, slave_readdatavalid})
                2'b10:   pending_count <= pending_count + 4'd1;
                2'b01:   pending_count <= pending_count - 4'd1;
                default: pending_count <= pending_count;
            endcase

            if (accept && out_of_range)             oob_error      <= 1'b1;
            if (accept && slave_read && slave_write) protocol_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vertex_buffer_responder.sv
// Directed bench: drivers push expected read data; a negedge monitor pops and compares.
module tb_vertex_buffer_responder;
    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [25:0] slave_address = '0;
    logic        slave_read = 1'b0;
    logic        slave_write = 1'b0;
    logic [3:0]  slave_byteenable = '0;
    logic [31:0] slave_writedata = '0;
    logic        slave_waitrequest;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;
    logic        resp_hold = 1'b0;
    logic [3:0]  pending_count;
    logic        oob_error;
    logic        protocol_error;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    int          acc_q[$];
    bit          chk_q[$];

    vertex_buffer_responder #(
        .DEPTH_LOG2(10), .READ_LATENCY(LAT), .MAX_PENDING(4)
    ) dut (
        .clock(clock), .reset(reset),
        .slave_address(slave_address), .slave_read(slave_read),
        .slave_write(slave_write), .slave_byteenable(slave_byteenable),
        .slave_writedata(slave_writedata), .slave_waitrequest(slave_waitrequest),
        .slave_readdata(slave_readdata), .slave_readdatavalid(slave_readdatavalid),
        .resp_hold(resp_hold), .pending_count(pending_count),
        .oob_error(oob_error), .protocol_error(protocol_error)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // drivers
    task automatic wait_ready(input string name);
        int n = 0;
        while (slave_waitrequest && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL %s_ready_timeout: got waitrequest=1 want 0", name);
        end
    endtask

    task automatic do_write(input logic [25:0] a, input logic [31:0] d, input logic [3:0] be);
        slave_address = a; slave_writedata = d; slave_byteenable = be; slave_write = 1'b1;
        wait_ready("write");
        @(posedge clock); #1;
        slave_write = 1'b0;
    endtask

    task automatic do_read(input logic [25:0] a, input logic [31:0] exp, input bit lat_chk);
        slave_address = a; slave_read = 1'b1;
        wait_ready("read");
        @(posedge clock); #1;
        slave_read = 1'b0;
        exp_q.push_back(exp);
        acc_q.push_back(cyc);
        chk_q.push_back(lat_chk);
    endtask

    task automatic do_read_write(input logic [25:0] a, input logic [31:0] d);
        slave_address = a; slave_writedata = d; slave_byteenable = 4'hF;
        slave_read = 1'b1; slave_write = 1'b1;
        wait_ready("rw");
        @(posedge clock); #1;
        slave_read = 1'b0; slave_write = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || pending_count != 4'd0) && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check("drain_done", 32'(n < 200), 32'd1);
        repeat (4) @(posedge clock);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (reset && slave_readdatavalid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_valid: got data %h want no response", slave_readdata);
            end else begin
                logic [31:0] e;
                int a;
                bit c;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                c = chk_q.pop_front();
                check("read_data", slave_readdata, e);
                if (c) check("read_latency", 32'(cyc - a), 32'(LAT));
            end
        end
    end

    initial begin
        // reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", {31'b0, slave_readdatavalid}, 32'd0);
        check("rst_data", slave_readdata, 32'h0);
        check("rst_pending", {28'b0, pending_count}, 32'd0);
        check("rst_oob", {31'b0, oob_error}, 32'd0);
        check("rst_proto", {31'b0, protocol_error}, 32'd0);
        check("rst_wait", {31'b0, slave_waitrequest}, 32'd0);
        reset = 1'b1;

        // basic write then read with latency
        do_write(26'h0, 32'h0000_0003, 4'hF);
        do_read(26'h0, 32'h0000_0003, 1'b1);
        wait_drain();

        // byte-lane merge; low address bits ignored
        do_write(26'h8, 32'hAABB_CCDD, 4'hF);
        do_write(26'h8, 32'h1122_3344, 4'b0101);
        do_read(26'h8, 32'hAA22_CC44, 1'b1);
        do_read(26'hB, 32'hAA22_CC44, 1'b1);
        wait_drain();

        // back-to-back held reads fill the window
        for (int i = 0; i < 4; i++) do_write(26'(32'h10 + 4 * i), 32'hA0A0_0001 + 32'(i), 4'hF);
        resp_hold = 1'b1;
        for (int i = 0; i < 4; i++) do_read(26'(32'h10 + 4 * i), 32'hA0A0_0001 + 32'(i), 1'b0);
        slave_address = 26'h20; slave_read = 1'b1;
        check("full_wait", {31'b0, slave_waitrequest}, 32'd1);
        check("full_pending", {28'b0, pending_count}, 32'd4);
        @(posedge clock); #1;
        slave_read = 1'b0;
        check("full_pending_hold", {28'b0, pending_count}, 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_no_valid", {31'b0, slave_readdatavalid}, 32'd0);
        end
        resp_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("release_consecutive", {31'b0, slave_readdatavalid}, 32'd1);
        end
        wait_drain();

        // read sees value before a following write
        do_read(26'h0, 32'h0000_0003, 1'b1);
        do_write(26'h0, 32'h0000_0005, 4'hF);
        do_read(26'h0, 32'h0000_0005, 1'b1);
        wait_drain();

        // out-of-range and protocol errors
        check("oob_before", {31'b0, oob_error}, 32'd0);
        do_read(26'h100_0000, 32'h0, 1'b1);
        check("oob_after_read", {31'b0, oob_error}, 32'd1);
        do_write(26'h100_0000, 32'hDEAD_BEEF, 4'hF);
        do_read(26'h0, 32'h0000_0005, 1'b1);
        wait_drain();
        check("proto_before", {31'b0, protocol_error}, 32'd0);
        do_read_write(26'h4, 32'h0000_0077);
        check("proto_after", {31'b0, protocol_error}, 32'd1);
        wait_drain();
        do_read(26'h4, 32'h0000_0077, 1'b1);
        wait_drain();

        // reset with reads in flight
        resp_hold = 1'b1;
        for (int i = 0; i < 3; i++) do_read(26'(32'h10 + 4 * i), 32'hA0A0_0001 + 32'(i), 1'b0);
        check("inflight_pending", {28'b0, pending_count}, 32'd3);
        #2 reset = 1'b0;
        #1;
        exp_q.delete(); acc_q.delete(); chk_q.delete();
        check("async_rst_pending", {28'b0, pending_count}, 32'd0);
        check("async_rst_valid", {31'b0, slave_readdatavalid}, 32'd0);
        check("async_rst_wait", {31'b0, slave_waitrequest}, 32'd0);
        check("async_rst_oob", {31'b0, oob_error}, 32'd0);
        check("async_rst_proto", {31'b0, protocol_error}, 32'd0);
        resp_hold = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        do_read(26'h8, 32'hAA22_CC44, 1'b1);
        do_read(26'h0, 32'h0000_0005, 1'b1);
        wait_drain();
        repeat (6) @(posedge clock);
        #1;
        check("final_pending", {28'b0, pending_count}, 32'd0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
